fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 8'h00, word address loaded into the PC on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 stall  input  1  decode not ready; hold PC and IF/ID register.
REQ-005 halt  input  1  request to stop fetching (enter HALT).
REQ-006 redirect_valid  input  1  branch/exception redirect from later stage.
REQ-007 redirect_addr  input  8  redirect target word address.
REQ-008 imem_addr  output  8  word address to instruction memory; equals PC register.
REQ-009 imem_instr  input  32  instruction read combinationally at imem_addr, same cycle.
REQ-010 ifid_valid  output  1  IF/ID register holds a live instruction.
REQ-011 ifid_instr  output  32  latched instruction.
REQ-012 ifid_pc  output  8  address of ifid_instr.
REQ-013 ifid_pc_plus1  output  8  ifid_pc+1 mod 256 (link value for jal).
REQ-014 halted  output  1  high while FSM is in HALT.
REQ-015 fetch_count  output  16  number of instructions loaded into IF/ID.

Function
REQ-016 PC is word-addressed, 8 bits; sequential next PC is PC+1, wrapping 8'hFF -> 8'h00.
REQ-017 FSM states: RUN, HALT; reset enters RUN.
REQ-018 Per-edge priority in RUN: redirect_valid > stall > halt > normal fetch.
REQ-019 Normal fetch (RUN, no redirect, no stall, no halt): ifid_instr<=imem_instr, ifid_pc<=PC, ifid_pc_plus1<=PC+1, ifid_valid<=1, PC<=next PC, fetch_count increments.
REQ-020 Jump predecode: in normal fetch, if imem_instr[31:26] is 6'b000010 (j) or 6'b000011 (jal), next PC SHALL be imem_instr[7:0] instead of PC+1; no bubble inserted.
REQ-021 Stall: PC, ifid_* and fetch_count hold; ifid_valid holds its value.
REQ-022 Redirect (any state, including during stall or HALT): PC<=redirect_addr, ifid_valid<=0, ifid_instr/pc unchanged, FSM<=RUN, fetch_count unchanged.
REQ-023 Halt in RUN without stall/redirect: FSM<=HALT, ifid_valid<=0, PC holds (instruction at PC not consumed).
REQ-024 HALT: PC, fetch_count hold; ifid_valid stays 0; halt/stall ignored; only redirect_valid exits (to RUN).
REQ-025 halted SHALL be 1 exactly when FSM is HALT.
REQ-026 fetch_count saturates at 16'hFFFF.
REQ-027 Latency: instruction at address A appears on ifid_instr one edge after PC==A with no stall.
REQ-028 imem_addr is a direct register output, no combinational path from any input.

Reset
REQ-029 On rst assertion, immediately and independent of clk: PC=RESET_PC, FSM=RUN, ifid_valid=0, ifid_instr=0, ifid_pc=0, ifid_pc_plus1=0, fetch_count=0, halted=0.
REQ-030 Reset asserted mid-operation (including during stall, HALT or a redirect cycle) SHALL override all other inputs; the first fetch occurs on the first rising edge after rst deasserts.

Verification
REQ-031 Reset, mem[0]=32'h012A4020, mem[1]=32'h02538822, no stall: edge1 -> ifid_instr=32'h012A4020, ifid_pc=0, ifid_valid=1; edge2 -> ifid_instr=32'h02538822, ifid_pc=1, fetch_count=2.
REQ-032 mem[2]=32'h0800003F (j 0x3F): after it is latched, imem_addr=8'h3F next cycle, ifid_pc_plus1=3; jal 32'h0C000010 at 3 -> imem_addr=8'h10.
REQ-033 Stall held 3 cycles with ifid_pc=1: ifid_*, imem_addr=2, fetch_count hold; release -> ifid_pc=2 next edge.
REQ-034 redirect_valid=1, redirect_addr=8'h80 while stall=1: next edge imem_addr=8'h80, ifid_valid=0; following edge ifid_pc=8'h80.
REQ-035 halt=1 at PC=5: halted=1, ifid_valid=0, imem_addr stays 5 for 10 cycles; redirect to 8'h05 -> halted=0, ifid_pc=5 one edge later.
REQ-036 PC=8'hFF sequential fetch -> imem_addr=8'h00, ifid_pc_plus1=8'h00; async rst pulse between edges -> outputs reset values before next edge.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: 8-bit word-addressed PC, IF/ID pipeline register,
// j/jal predecode, stall/redirect/halt handling and a saturating fetch counter.
module fetch_stage #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        halt,
    input  logic        redirect_valid,
    input  logic [7:0]  redirect_addr,
    output logic [7:0]  imem_addr,
    input  logic [31:0] imem_instr,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [7:0]  ifid_pc,
    output logic [7:0]  ifid_pc_plus1,
    output logic        halted,
    output logic [15:0] fetch_count
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [7:0]  id_pc_q, id_pc_d;
    logic [7:0]  id_pc_p1_q, id_pc_p1_d;
    logic [15:0] count_q, count_d;

    logic [7:0]  pc_plus1;
    logic        is_jump;

    assign pc_plus1 = pc_q + 8'd1;
    assign is_jump  = (imem_instr[31:26] == 6'b000010) || (imem_instr[31:26] == 6'b000011);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_RUN;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            instr_q    <= '0;
            id_pc_q    <= '0;
            id_pc_p1_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            id_pc_q    <= id_pc_d;
            id_pc_p1_q <= id_pc_p1_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        id_pc_d    = id_pc_q;
        id_pc_p1_d = id_pc_p1_q;
        count_d    = count_q;

        // Redirect wins from either state; stall/halt only matter while running.
        if (redirect_valid) begin
            state_d = S_RUN;
            pc_d    = redirect_addr;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                S_RUN: begin
                    if (stall) begin
                        // hold everything
                    end else if (halt) begin
                        state_d = S_HALT;
                        valid_d = 1'b0;
                    end else begin
                        instr_d    = imem_instr;
                        id_pc_d    = pc_q;
                        id_pc_p1_d = pc_plus1;
                        valid_d    = 1'b1;
                        pc_d       = is_jump ? imem_instr[7:0] : pc_plus1;
                        count_d    = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
                    end
                end
                S_HALT: begin
                    valid_d = 1'b0;
                end
                default: begin
                    state_d = S_RUN;
                end
            endcase
        end
    end

    assign imem_addr     = pc_q;
    assign ifid_valid    = valid_q;
    assign ifid_instr    = instr_q;
    assign ifid_pc       = id_pc_q;
    assign ifid_pc_plus1 = id_pc_p1_q;
    assign halted        = (state_q == S_HALT);
    assign fetch_count   = count_q;

endmodule
